// File: rtl/mem_arbiter.sv
// Burst-read memory port arbiter: port 0 fixed priority, ports 1..N-1 round-robin,
// with an in-flight ID queue that steers returned words back to the issuing requester.
module mem_arbiter #(
  parameter int AN    = 24,
  parameter int DN    = 16,
  parameter int N     = 4,
  parameter int BURST = 8,
  parameter int QD    = 4
) (
  input  logic            clkSYS,
  input  logic            aclr,
  input  logic [N-1:0]    req,
  input  logic [N*AN-1:0] req_addr,
  output logic [N-1:0]    req_ack,
  output logic [DN-1:0]   rd_data,
  output logic [N-1:0]    rd_valid,
  output logic            mem_req,
  output logic [AN-1:0]   mem_addr,
  input  logic            mem_ack,
  input  logic [DN-1:0]   mem_data,
  input  logic            mem_valid,
  output logic            busy,
  output logic            err
);

  localparam int GW = $clog2(N);
  localparam int QW = $clog2(QD);
  localparam int BW = $clog2(BURST);
  localparam logic [GW:0]   N_W       = (GW+1)'(N);
  localparam logic [GW-1:0] LAST_PORT = GW'(N-1);
  localparam logic [GW-1:0] ONE_PORT  = GW'(1);
  localparam logic [QW:0]   QD_W      = (QW+1)'(QD);
  localparam logic [BW-1:0] LAST_WORD = BW'(BURST-1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t          state_q;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   rr_q;
  logic            mem_req_q;
  logic [AN-1:0]   mem_addr_q;
  logic            err_q;
  logic [GW-1:0]   id_q [QD];
  logic [QW-1:0]   wr_ptr_q;
  logic [QW-1:0]   rd_ptr_q;
  logic [QW:0]     cnt_q;
  logic [QW:0]     cnt_d;
  logic [BW-1:0]   wcnt_q;

  logic            gnt_valid_s;
  logic [GW-1:0]   gnt_idx_s;
  logic [GW:0]     cand_s;
  logic [GW-1:0]   cand_idx_s;
  logic [AN-1:0]   sel_addr_s;
  logic            push_s;
  logic            pop_s;
  logic            q_empty_s;
  logic            q_full_s;
  logic [GW-1:0]   head_s;

  assign q_empty_s = (cnt_q == '0);
  assign q_full_s  = (cnt_q == QD_W);
  assign head_s    = id_q[rd_ptr_q];
  assign push_s    = (state_q == S_ISSUE) && mem_ack;
  assign pop_s     = mem_valid && !q_empty_s && (wcnt_q == LAST_WORD);

  // Grant selection: descending scan so the candidate closest to rr_q wins; port 0 overrides.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_idx_s   = '0;
    cand_s      = '0;
    cand_idx_s  = '0;
    sel_addr_s  = '0;
    for (int k = N-2; k >= 0; k--) begin
      cand_s      = {1'b0, rr_q} + (GW+1)'(k);
      cand_s      = (cand_s >= N_W) ? (cand_s - (N_W - (GW+1)'(1))) : cand_s;
      cand_idx_s  = cand_s[GW-1:0];
      gnt_valid_s = gnt_valid_s | req[cand_idx_s];
      gnt_idx_s   = req[cand_idx_s] ? cand_idx_s : gnt_idx_s;
    end
    gnt_valid_s = gnt_valid_s | req[0];
    gnt_idx_s   = req[0] ? '0 : gnt_idx_s;
    for (int i = 0; i < N; i++) begin
      sel_addr_s = (gnt_idx_s == GW'(i)) ? req_addr[i*AN +: AN] : sel_addr_s;
    end
  end

  // Acknowledge and return-data strobes, steered by the granted port and the queue head.
  always_comb begin
    req_ack  = '0;
    rd_valid = '0;
    if (push_s) begin
      req_ack[grant_q] = 1'b1;
    end else begin
      req_ack = '0;
    end
    if (mem_valid && !q_empty_s) begin
      rd_valid[head_s] = 1'b1;
    end else begin
      rd_valid = '0;
    end
  end

  // Queue occupancy next state.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + (QW+1)'(1);
      2'b01:   cnt_d = cnt_q - (QW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  assign rd_data  = mem_data;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign busy     = !q_empty_s || mem_req_q;
  assign err      = err_q;

  // Arbitration FSM with registered request/address outputs and round-robin pointer.
  always_ff @(posedge clkSYS or posedge aclr) begin
    if (aclr) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      rr_q       <= ONE_PORT;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_valid_s && !q_full_s) begin
            grant_q    <= gnt_idx_s;
            mem_addr_q <= sel_addr_s;
            mem_req_q  <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= S_GAP;
            if (grant_q != '0) begin
              rr_q <= (grant_q == LAST_PORT) ? ONE_PORT : (grant_q + ONE_PORT);
            end
          end
        end
        S_GAP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // In-flight ID queue, beat counter and sticky orphan-data flag.
  always_ff @(posedge clkSYS or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < QD; i++) begin
        id_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      wcnt_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push_s) begin
        id_q[wr_ptr_q] <= grant_q;
        wr_ptr_q       <= wr_ptr_q + QW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + QW'(1);
      end
      cnt_q <= cnt_d;
      if (mem_valid && !q_empty_s) begin
        wcnt_q <= wcnt_q + BW'(1);
      end
      if (mem_valid && q_empty_s) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

  logic        clkSYS;
  logic        aclr;
  logic [3:0]  req;
  logic [95:0] req_addr;
  logic [3:0]  req_ack;
  logic [15:0] rd_data;
  logic [3:0]  rd_valid;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        mem_valid;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [23:0] addr_tab [4];

  mem_arbiter dut (
    .clkSYS    (clkSYS),
    .aclr      (aclr),
    .req       (req),
    .req_addr  (req_addr),
    .req_ack   (req_ack),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .mem_valid (mem_valid),
    .busy      (busy),
    .err       (err)
  );

  initial clkSYS = 1'b0;
  always #5 clkSYS = ~clkSYS;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clkSYS);
      #1;
    end
  endtask

  task automatic do_reset();
    aclr      = 1'b1;
    req       = 4'b0000;
    mem_ack   = 1'b0;
    mem_valid = 1'b0;
    mem_data  = 16'h0000;
    step(2);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", {8'd0, mem_addr}, 32'd0);
    chk("rst_req_ack", {28'd0, req_ack}, 32'd0);
    chk("rst_busy_err", {30'd0, busy, err}, 32'd0);
    aclr = 1'b0;
  endtask

  task automatic wait_req();
    for (int c = 0; c < 20 && !mem_req; c++) begin
      step(1);
    end
    chk("mem_req_rise", {31'd0, mem_req}, 32'd1);
  endtask

  // Wait for mem_req, verify address, ack immediately, verify one-hot req_ack.
  task automatic grant(input int p, input logic [3:0] next_req);
    wait_req();
    chk("mem_addr", {8'd0, mem_addr}, {8'd0, addr_tab[p]});
    mem_ack = 1'b1;
    #1;
    chk("req_ack", {28'd0, req_ack}, 32'd1 << p);
    step(1);
    mem_ack = 1'b0;
    req     = next_req;
  endtask

  task automatic send_words(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      mem_valid = 1'b1;
      mem_data  = 16'hA000 | 16'(p << 8) | 16'(i);
      #1;
      chk("rd_valid", {28'd0, rd_valid}, 32'd1 << p);
      chk("rd_data", {16'd0, rd_data}, {16'd0, 16'hA000 | 16'(p << 8) | 16'(i)});
      step(1);
    end
    mem_valid = 1'b0;
  endtask

  initial begin
    addr_tab[0] = 24'h1C0000;
    addr_tab[1] = 24'h2C0101;
    addr_tab[2] = 24'h3C0202;
    addr_tab[3] = 24'h4C0303;
    req_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
    aclr = 1'b1;
    #2;

    // Round robin between ports 1 and 2
    do_reset();
    req = 4'b0110;
    grant(1, 4'b0110);
    grant(2, 4'b0110);
    grant(1, 4'b0110);
    grant(2, 4'b0000);
    chk("t1_busy", {31'd0, busy}, 32'd1);

    // Port 0 priority, then round robin resumes; queue full blocks the fifth grant
    do_reset();
    req = 4'b1111;
    grant(0, 4'b1111);
    grant(0, 4'b1110);
    grant(1, 4'b1110);
    grant(2, 4'b1000);
    for (int c = 0; c < 4; c++) begin
      step(1);
      chk("full_no_req", {31'd0, mem_req}, 32'd0);
    end
    send_words(0, 8);
    chk("pop_cycle_no_req", {31'd0, mem_req}, 32'd0);
    step(1);
    chk("grant_after_pop", {31'd0, mem_req}, 32'd1);
    grant(3, 4'b0000);

    // Bursts for ports 3 then 0 return in order and drain the queue
    do_reset();
    req = 4'b1000;
    grant(3, 4'b0001);
    grant(0, 4'b0000);
    step(5);
    chk("t3_busy_pending", {31'd0, busy}, 32'd1);
    send_words(3, 8);
    send_words(0, 8);
    chk("t3_drained", {30'd0, busy, err}, 32'd0);

    // Orphan data raises sticky err
    mem_valid = 1'b1;
    mem_data  = 16'h5555;
    #1;
    chk("orphan_rd_valid", {28'd0, rd_valid}, 32'd0);
    step(1);
    mem_valid = 1'b0;
    chk("err_set", {31'd0, err}, 32'd1);
    step(3);
    chk("err_sticky", {31'd0, err}, 32'd1);

    // Reset during ISSUE
    req = 4'b0100;
    wait_req();
    mem_ack = 1'b1;
    aclr    = 1'b1;
    #1;
    chk("aclr_issue_req_ack", {28'd0, req_ack}, 32'd0);
    chk("aclr_issue_mem_req", {31'd0, mem_req}, 32'd0);
    chk("aclr_issue_err", {30'd0, busy, err}, 32'd0);
    mem_ack = 1'b0;
    req     = 4'b0101;
    step(1);
    aclr = 1'b0;
    grant(0, 4'b0000);

    // Reset mid-return
    step(2);
    send_words(0, 3);
    mem_valid = 1'b1;
    aclr      = 1'b1;
    #1;
    chk("aclr_ret_rd_valid", {28'd0, rd_valid}, 32'd0);
    chk("aclr_ret_busy_err", {30'd0, busy, err}, 32'd0);
    step(1);
    mem_valid = 1'b0;
    aclr      = 1'b0;
    req       = 4'b0110;
    grant(1, 4'b0000);
    chk("post_aclr_err", {31'd0, err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
